// File: rtl/uart_tx.sv
// UART transmitter: start bit, BIT data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit between data and stop.
module uart_tx #(
    parameter int unsigned CLK_FREQ  = 20000000,
    parameter int unsigned BAUD_RATE = 57600,
    parameter int unsigned BIT       = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [BIT-1:0] tx_data,
    input  logic           tx_data_start,
    output logic           tx_ready,
    output logic           tx_done,
    output logic           tx_pin
);

    localparam int unsigned     CYCLE    = CLK_FREQ / BAUD_RATE;
    localparam int unsigned     CW       = (CYCLE > 1) ? $clog2(CYCLE) : 1;
    localparam logic [CW-1:0]   CYC_LAST = CW'(CYCLE - 1);
    localparam logic [3:0]      BIT_LAST = 4'(BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cyc_q, cyc_d;
    logic [3:0]     bit_q, bit_d;
    logic [BIT-1:0] shift_q, shift_d;
    logic           pin_q, pin_d;
    logic           ready_q, ready_d;
    logic           done_q, done_d;
    logic           bit_end;
`ifdef UART_TX_PARITY_EN
    logic           par_q, par_d;
`endif

    assign bit_end  = (cyc_q == CYC_LAST);
    assign tx_pin   = pin_q;
    assign tx_ready = ready_q;
    assign tx_done  = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            pin_q   <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            pin_q   <= pin_d;
            ready_q <= ready_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q + 1'b1;
        bit_d   = '0;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                cyc_d = '0;
                if (tx_data_start) begin
                    state_d = S_START;
                    shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^tx_data;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                bit_d = bit_q;
                if (bit_end) begin
                    cyc_d   = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cyc_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pin changes on the accepting edge.
    always_comb begin
        pin_d   = 1'b1;
        ready_d = 1'b0;
        done_d  = (state_q == S_STOP) && bit_end;
        case (state_d)
            S_IDLE:   ready_d = 1'b1;
            S_START:  pin_d   = 1'b0;
            S_DATA:   pin_d   = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: pin_d   = par_d;
`endif
            default:  pin_d   = 1'b1;
        endcase
    end

endmodule
